// File: rtl/rf_wport_sched.sv
// Write-port scheduler for the integer register file: zero-fills x1..xN after reset,
// then round-robins the single write port between writeback and the LSU.
module rf_wport_sched #(
    parameter bit                    RV32E       = 1'b0,
    parameter int unsigned           DataWidth   = 32,
    parameter logic [DataWidth-1:0]  WordZeroVal = '0,
    parameter bit                    InitOnReset = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wb_valid_i,
    input  logic [4:0]           wb_addr_i,
    input  logic [DataWidth-1:0] wb_data_i,
    output logic                 wb_ready_o,
    input  logic                 lsu_valid_i,
    input  logic [4:0]           lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_data_i,
    output logic                 lsu_ready_o,
    output logic [4:0]           waddr_a_o,
    output logic [DataWidth-1:0] wdata_a_o,
    output logic                 we_a_o,
    output logic                 init_done_o,
    output logic                 illegal_addr_o
);

    localparam int unsigned NumRegs  = RV32E ? 16 : 32;
    localparam logic [4:0]  LastReg  = 5'(NumRegs - 1);
    localparam logic [0:0]  ST_INIT  = 1'b0;
    localparam logic [0:0]  ST_RUN   = 1'b1;
    localparam logic [0:0]  ST_RESET = InitOnReset ? ST_INIT : ST_RUN;

    typedef struct packed {
        logic [4:0]           addr;
        logic [DataWidth-1:0] data;
    } wreq_t;

    logic [0:0] state;
    logic [4:0] cnt;
    logic       prio_lsu;
    logic       run;
    logic       grant_wb;
    logic       grant_lsu;
    logic       accept;
    logic       sel_illegal;
    wreq_t      sel;

    // Ready is masked by reset so a request in the reset cycle is never accepted.
    assign run         = (state == ST_RUN) && !rst_i;
    assign grant_wb    = wb_valid_i  && (!lsu_valid_i || !prio_lsu);
    assign grant_lsu   = lsu_valid_i && (!wb_valid_i  ||  prio_lsu);
    assign wb_ready_o  = run && grant_wb;
    assign lsu_ready_o = run && grant_lsu;
    assign accept      = wb_ready_o || lsu_ready_o;
    assign init_done_o = (state == ST_RUN);

    assign sel         = grant_wb ? wreq_t'{wb_addr_i, wb_data_i} : wreq_t'{lsu_addr_i, lsu_data_i};
    assign sel_illegal = RV32E && sel.addr[4];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= ST_RESET;
            cnt            <= 5'd1;
            prio_lsu       <= 1'b0;
            waddr_a_o      <= '0;
            wdata_a_o      <= '0;
            we_a_o         <= 1'b0;
            illegal_addr_o <= 1'b0;
        end else if (state == ST_INIT) begin
            waddr_a_o      <= cnt;
            wdata_a_o      <= WordZeroVal;
            we_a_o         <= 1'b1;
            illegal_addr_o <= 1'b0;
            cnt            <= cnt + 5'd1;
            if (cnt == LastReg) state <= ST_RUN;
        end else if (accept) begin
            // x0 and out-of-range RV32E targets consume the slot but never write.
            waddr_a_o      <= sel.addr;
            wdata_a_o      <= sel.data;
            we_a_o         <= (sel.addr != 5'd0) && !sel_illegal;
            illegal_addr_o <= sel_illegal;
            prio_lsu       <= grant_wb;
        end else begin
            we_a_o         <= 1'b0;
            illegal_addr_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rf_wport_sched.sv
// Scoreboard bench for rf_wport_sched: three configurations (RV32 init, RV32E init,
// no-init), expected writes queued at accept time and popped by a write monitor.
module tb_rf_wport_sched;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
        logic        w;
        logic        i;
    } exp_t;

    logic        clk;
    logic        rst [3];
    logic        wbv [3];
    logic [4:0]  wba [3];
    logic [31:0] wbd [3];
    logic        wbr [3];
    logic        lsv [3];
    logic [4:0]  lsa [3];
    logic [31:0] lsd [3];
    logic        lsr [3];
    logic [4:0]  wa  [3];
    logic [31:0] wd  [3];
    logic        we  [3];
    logic        dn  [3];
    logic        il  [3];

    exp_t q [3][$];
    int   checks = 0;
    int   passes = 0;

    localparam logic [31:0] Wzv = 32'hC0DE_0000;

    rf_wport_sched #(.RV32E(1'b0), .DataWidth(32), .WordZeroVal(Wzv), .InitOnReset(1'b1)) u_a (
        .clk_i(clk), .rst_i(rst[0]),
        .wb_valid_i(wbv[0]), .wb_addr_i(wba[0]), .wb_data_i(wbd[0]), .wb_ready_o(wbr[0]),
        .lsu_valid_i(lsv[0]), .lsu_addr_i(lsa[0]), .lsu_data_i(lsd[0]), .lsu_ready_o(lsr[0]),
        .waddr_a_o(wa[0]), .wdata_a_o(wd[0]), .we_a_o(we[0]),
        .init_done_o(dn[0]), .illegal_addr_o(il[0]));

    rf_wport_sched #(.RV32E(1'b1), .DataWidth(32), .WordZeroVal(Wzv), .InitOnReset(1'b1)) u_b (
        .clk_i(clk), .rst_i(rst[1]),
        .wb_valid_i(wbv[1]), .wb_addr_i(wba[1]), .wb_data_i(wbd[1]), .wb_ready_o(wbr[1]),
        .lsu_valid_i(lsv[1]), .lsu_addr_i(lsa[1]), .lsu_data_i(lsd[1]), .lsu_ready_o(lsr[1]),
        .waddr_a_o(wa[1]), .wdata_a_o(wd[1]), .we_a_o(we[1]),
        .init_done_o(dn[1]), .illegal_addr_o(il[1]));

    rf_wport_sched #(.RV32E(1'b0), .DataWidth(32), .WordZeroVal(32'h0), .InitOnReset(1'b0)) u_c (
        .clk_i(clk), .rst_i(rst[2]),
        .wb_valid_i(wbv[2]), .wb_addr_i(wba[2]), .wb_data_i(wbd[2]), .wb_ready_o(wbr[2]),
        .lsu_valid_i(lsv[2]), .lsu_addr_i(lsa[2]), .lsu_data_i(lsd[2]), .lsu_ready_o(lsr[2]),
        .waddr_a_o(wa[2]), .wdata_a_o(wd[2]), .we_a_o(we[2]),
        .init_done_o(dn[2]), .illegal_addr_o(il[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input int d, input logic [4:0] a, input logic [31:0] data,
                        input logic w, input logic i);
        exp_t e;
        e.a = a; e.d = data; e.w = w; e.i = i;
        q[d].push_back(e);
    endtask

    task automatic push_walk(input int d, input int last);
        for (int k = 1; k <= last; k++) push(d, 5'(k), Wzv, 1'b1, 1'b0);
    endtask

    // Any visible write or illegal pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (we[d] === 1'b1 || il[d] === 1'b1) begin
                if (q[d].size() == 0) begin
                    checks++;
                    $display("FAIL dut%0d_unexpected: got addr %0d data %h we %b ill %b, expected no write",
                             d, wa[d], wd[d], we[d], il[d]);
                end else begin
                    exp_t e;
                    e = q[d].pop_front();
                    chk($sformatf("dut%0d_addr", d), 32'(wa[d]), 32'(e.a));
                    chk($sformatf("dut%0d_data", d), wd[d], e.d);
                    chk($sformatf("dut%0d_we", d), 32'(we[d]), 32'(e.w));
                    chk($sformatf("dut%0d_ill", d), 32'(il[d]), 32'(e.i));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            wbv[d] = 1'b0; wba[d] = '0; wbd[d] = '0;
            lsv[d] = 1'b0; lsa[d] = '0; lsd[d] = '0;
        end
        lsv[2] = 1'b1; lsa[2] = 5'd3; lsd[2] = 32'h1234;

        // No-init config: reset wins over a held LSU request, then accepted on the first free cycle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("c_rst_init_done", 32'(dn[2]), 1);
        chk("c_rst_lsu_ready", 32'(lsr[2]), 0);
        chk("c_rst_we", 32'(we[2]), 0);
        @(posedge clk); #1 rst[2] = 1'b0;
        @(negedge clk);
        chk("c_first_init_done", 32'(dn[2]), 1);
        chk("c_first_lsu_ready", 32'(lsr[2]), 1);
        push(2, 5'd3, 32'h1234, 1'b1, 1'b0);
        @(posedge clk); #1 lsv[2] = 1'b0;

        // RV32 walk with a WB request held through reset and the whole walk.
        wbv[0] = 1'b1; wba[0] = 5'd7; wbd[0] = 32'h77;
        @(negedge clk);
        chk("a_rst_we", 32'(we[0]), 0);
        chk("a_rst_waddr", 32'(wa[0]), 0);
        chk("a_rst_wdata", wd[0], 0);
        chk("a_rst_ill", 32'(il[0]), 0);
        chk("a_rst_init_done", 32'(dn[0]), 0);
        chk("a_rst_wb_ready", 32'(wbr[0]), 0);
        push_walk(0, 31);
        @(posedge clk); #1 rst[0] = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("a_walk%0d_init_done", k), 32'(dn[0]), 32'(k == 31));
            chk($sformatf("a_walk%0d_wb_ready", k), 32'(wbr[0]), 32'(k == 31));
        end
        push(0, 5'd7, 32'h77, 1'b1, 1'b0);
        @(posedge clk); #1;
        wbv[0] = 1'b0;
        lsv[0] = 1'b1; lsa[0] = 5'd9; lsd[0] = 32'h99;
        @(negedge clk);
        chk("a_lsu_solo_ready", 32'(lsr[0]), 1);
        push(0, 5'd9, 32'h99, 1'b1, 1'b0);

        // Both valid: pointer sits at WB after the LSU grant, so WB, LSU, WB, LSU.
        @(posedge clk); #1;
        wbv[0] = 1'b1; wba[0] = 5'd5; wbd[0] = 32'hA;
        lsv[0] = 1'b1; lsa[0] = 5'd6; lsd[0] = 32'hB;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("a_rr%0d_wb_ready", i), 32'(wbr[0]), 32'(i % 2 == 0));
            chk($sformatf("a_rr%0d_lsu_ready", i), 32'(lsr[0]), 32'(i % 2 == 1));
            if (i % 2 == 0) push(0, 5'd5, 32'hA, 1'b1, 1'b0);
            else            push(0, 5'd6, 32'hB, 1'b1, 1'b0);
            @(posedge clk); #1;
        end
        lsv[0] = 1'b0;
        wba[0] = 5'd0; wbd[0] = 32'hEE;
        @(negedge clk);
        chk("a_x0_wb_ready", 32'(wbr[0]), 1);
        @(posedge clk); #1 wbv[0] = 1'b0;
        @(negedge clk);
        chk("a_x0_we", 32'(we[0]), 0);

        // Reset at walk cycle 10 drops the walk; it restarts from x1.
        @(posedge clk); #1 rst[0] = 1'b1;
        @(posedge clk); #1 rst[0] = 1'b0;
        push_walk(0, 10);
        repeat (10) @(posedge clk);
        #1 rst[0] = 1'b1;
        push_walk(0, 31);
        @(posedge clk); #1 rst[0] = 1'b0;
        @(negedge clk);
        chk("a_midrst_we", 32'(we[0]), 0);
        chk("a_midrst_waddr", 32'(wa[0]), 0);
        chk("a_midrst_init_done", 32'(dn[0]), 0);
        for (int k = 1; k <= 31; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("a_rewalk%0d_init_done", k), 32'(dn[0]), 32'(k == 31));
        end

        // RV32E: 15-entry walk, then an out-of-range LSU write and a legal WB write.
        push_walk(1, 15);
        @(posedge clk); #1 rst[1] = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("b_walk%0d_init_done", k), 32'(dn[1]), 32'(k == 15));
        end
        @(posedge clk); #1;
        lsv[1] = 1'b1; lsa[1] = 5'd20; lsd[1] = 32'h55;
        @(negedge clk);
        chk("b_ill_lsu_ready", 32'(lsr[1]), 1);
        push(1, 5'd20, 32'h55, 1'b0, 1'b1);
        @(posedge clk); #1;
        lsv[1] = 1'b0;
        wbv[1] = 1'b1; wba[1] = 5'd3; wbd[1] = 32'h33;
        @(negedge clk);
        chk("b_wb_ready", 32'(wbr[1]), 1);
        push(1, 5'd3, 32'h33, 1'b1, 1'b0);
        @(posedge clk); #1 wbv[1] = 1'b0;
        @(negedge clk);
        chk("b_ill_pulse_end", 32'(il[1]), 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk($sformatf("dut%0d_queue_left", d), 32'(q[d].size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rf_wport_sched.md
# rf_wport_sched

Write-port scheduler for the integer register file. It owns the file's single write port (W1) and shares it between two requesters: the writeback stage and the load/store unit. After every reset it first walks the file and writes `WordZeroVal` to every architectural register except x0, so the file never exposes X or stale data. It sits between the ID/WB pipeline and `ibex_register_file_ff`, driving that block's `waddr_a_i`, `wdata_a_i` and `we_a_i`.

## Interface
Parameters:
- `RV32E`, 0: when 1, the file holds 16 registers (NumRegs=16); otherwise 32.
- `DataWidth`, 32: register data width.
- `WordZeroVal`, '0: value written during the init walk.
- `InitOnReset`, 1: when 0, the init walk is skipped.

Ports:
- `clk_i`, in, 1: the only clock; every flop is on its rising edge.
- `rst_i`, in, 1: reset, synchronous and active-high.
- `wb_valid_i`, in, 1: writeback request valid.
- `wb_addr_i`, in, 5: writeback destination register.
- `wb_data_i`, in, DataWidth: writeback data.
- `wb_ready_o`, out, 1: writeback request accepted this cycle.
- `lsu_valid_i`, in, 1: LSU load-return request valid.
- `lsu_addr_i`, in, 5: LSU destination register.
- `lsu_data_i`, in, DataWidth: LSU data.
- `lsu_ready_o`, out, 1: LSU request accepted this cycle.
- `waddr_a_o`, out, 5: register-file write address (registered).
- `wdata_a_o`, out, DataWidth: register-file write data (registered).
- `we_a_o`, out, 1: register-file write enable (registered).
- `init_done_o`, out, 1: init walk complete; the port is available to requesters.
- `illegal_addr_o`, out, 1: one-cycle pulse when a dropped RV32E out-of-range write is accepted (registered).

## Operation
- FSM states: INIT and RUN.
  - `rst_i`=1 forces INIT if `InitOnReset`=1, otherwise RUN.
  - INIT advances to RUN after the last init write. RUN has no exit except reset.
- `init_done_o` = (state==RUN), combinational from the state flop.
- Init counter `cnt`:
  - Width 5. Reset value 1.
  - In INIT, each cycle the output registers load addr=`cnt`, data=`WordZeroVal`, we=1, then `cnt` increments.
  - When `cnt`==NumRegs-1 is issued, the state goes to RUN. There is no wrap; x0 is never written.
- During INIT both ready outputs are 0. Requesters hold their valid/data, per standard valid/ready rules.
- RUN arbitration is round-robin with a 1-bit priority pointer.
  - Pointer reset value: WB has priority.
  - Only one requester valid: that requester is granted.
  - Both valid: the pointer's owner is granted.
  - After any grant, the pointer points to the non-granted requester.
  - `*_ready_o` = state==RUN && grant; combinational from the valids and the pointer.
- Accepted request (valid && ready at edge N): the output registers load its addr and data.
  - `we_a_o`=1 after edge N, except for the two cases below.
  - Addr 0: accepted, but `we_a_o`=0. x0 writes are silently discarded.
  - `RV32E`=1 and addr[4]=1: accepted, `we_a_o`=0, and `illegal_addr_o`=1 for that cycle.
- With no accept (and not in INIT), `we_a_o`=0 and `illegal_addr_o`=0. `waddr_a_o` and `wdata_a_o` hold their last values.
- No buffering: at most one write per cycle; the losing requester stalls.

## Timing
- Reset values:
  - `we_a_o`=0, `waddr_a_o`=0, `wdata_a_o`=0, `illegal_addr_o`=0, pointer=WB.
  - `init_done_o`=!`InitOnReset`.
  - Ready outputs are 0 while `rst_i`=1.
- Init walk, counting edge 1 as the first edge with `rst_i`=0:
  - After edge k (k=1..NumRegs-1): `we_a_o`=1, `waddr_a_o`=k.
  - After edge NumRegs-1: `init_done_o`=1.
  - Requesters can be accepted from the cycle following edge NumRegs-1; their writes appear after the next edge.
- Request latency: accept at edge N, write visible on `we_a_o` in cycle N+1. Sustained rate is 1 write per cycle.
- Reset mid-walk or mid-traffic: takes effect at the next edge.
  - Outputs return to reset values and an in-flight registered write is dropped.
  - The walk restarts at `cnt`=1.
- Reset and valid in the same cycle: reset wins; no accept.

## Test plan
- Reset release, `RV32E`=0, `InitOnReset`=1 -> `we_a_o`=1 for 31 consecutive cycles with addr 1..31 and data `WordZeroVal`; `init_done_o` rises after edge 31; both readies stay 0 throughout.
- Both valid for 4 cycles (WB addr 5/data 0xA, LSU addr 6/data 0xB) -> grants alternate WB, LSU, WB, LSU; writes appear one cycle after each accept.
- WB valid with addr 0 -> `wb_ready_o`=1, `we_a_o` stays 0; `RV32E`=1, LSU addr 20 -> accepted, `we_a_o`=0, `illegal_addr_o` pulses for 1 cycle.
- `rst_i` asserted at walk cycle 10 for 1 cycle -> `we_a_o`=0 next cycle; the walk restarts at addr 1 and `init_done_o` stays 0 until the full walk ends.
- `InitOnReset`=0, LSU valid (addr 3/data 0x1234) on the first cycle after reset -> `init_done_o`=1 and `lsu_ready_o`=1 that cycle; the next cycle shows `we_a_o`=1, addr 3, data 0x1234.
